// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between the instruction-fetch requester and
// the load/store requester. One requester is granted at a time and at most one
// memory transaction is outstanding. Each memory response is routed back to
// the requester that issued the transaction.
//
// Data accesses win ties. A saturating starvation counter counts data grants
// made while fetch was also waiting. Once it reaches STARVE_LIMIT, the next
// contested grant goes to fetch.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   if_req_valid/_ready, if_addr      fetch request (read only)
//   if_rsp_valid, if_rdata            fetch response, 1-cycle pulse
//   d_req_valid/_ready, d_addr,       load/store request
//   d_we, d_wdata, d_wstrb
//   d_rsp_valid, d_rdata              load data or store ack (rdata=0), pulse
//   mem_req_valid/_ready, mem_addr,   registered memory request
//   mem_we, mem_wdata, mem_wstrb
//   mem_rsp_valid, mem_rdata          memory response, one per request
//   busy                              a transaction is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   // instruction fetch
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rdata,
   // load/store
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_we,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rdata,
   // memory
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   state_e              state_q,         state_d;
   owner_e              owner_q,         owner_d;
   logic [CNT_W-1:0]    starve_q,        starve_d;
   logic [ADDR_W-1:0]   addr_q,          addr_d;
   logic                we_q,            we_d;
   logic [DATA_W-1:0]   wdata_q,         wdata_d;
   logic [STRB_W-1:0]   wstrb_q,         wstrb_d;
   logic                mem_req_valid_q, mem_req_valid_d;
   logic                busy_q,          busy_d;
   logic                if_rsp_valid_q,  if_rsp_valid_d;
   logic [DATA_W-1:0]   if_rdata_q,      if_rdata_d;
   logic                d_rsp_valid_q,   d_rsp_valid_d;
   logic [DATA_W-1:0]   d_rdata_q,       d_rdata_d;

   // Arbitration. Data wins unless fetch has been passed over STARVE_LIMIT
   // times in a row while it was waiting.
   logic fetch_starved;
   logic grant_d;
   logic grant_if;
   logic in_idle;

   assign fetch_starved = if_req_valid && (starve_q == CNT_MAX);
   assign grant_d       = d_req_valid && !fetch_starved;
   assign grant_if      = if_req_valid && !grant_d;

   // Readies are the only combinational outputs. They are gated with reset_n
   // so that every output reads 0 while reset is asserted, even if a
   // requester is still holding its valid high.
   assign in_idle      = reset_n && (state_q == ST_IDLE);
   assign if_req_ready = in_idle && grant_if;
   assign d_req_ready  = in_idle && grant_d;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement leaves a value unassigned and no latch
   // is inferred.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      starve_d        = starve_q;
      addr_d          = addr_q;
      we_d            = we_q;
      wdata_d         = wdata_q;
      wstrb_d         = wstrb_q;
      mem_req_valid_d = mem_req_valid_q;
      busy_d          = busy_q;
      if_rsp_valid_d  = 1'b0;
      if_rdata_d      = if_rdata_q;
      d_rsp_valid_d   = 1'b0;
      d_rdata_d       = d_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               owner_d         = OWN_D;
               addr_d          = d_addr;
               we_d            = d_we;
               wdata_d         = d_wdata;
               // Strobes only mean something for a store.
               wstrb_d         = d_we ? d_wstrb : '0;
               state_d         = ST_REQ;
               mem_req_valid_d = 1'b1;
               busy_d          = 1'b1;
               if (if_req_valid && (starve_q != CNT_MAX)) begin
                  starve_d = starve_q + CNT_W'(1);
               end
            end else if (grant_if) begin
               owner_d         = OWN_IF;
               addr_d          = if_addr;
               we_d            = 1'b0;
               wdata_d         = '0;
               wstrb_d         = '0;
               state_d         = ST_REQ;
               mem_req_valid_d = 1'b1;
               busy_d          = 1'b1;
               starve_d        = '0;
            end
         end

         ST_REQ: begin
            if (mem_req_ready) begin
               state_d         = ST_RSP;
               mem_req_valid_d = 1'b0;
            end
         end

         ST_RSP: begin
            // Responses seen in any other state are stray and dropped.
            if (mem_rsp_valid) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (owner_q == OWN_D) begin
                  d_rsp_valid_d = 1'b1;
                  d_rdata_d     = we_q ? '0 : mem_rdata;
               end else begin
                  if_rsp_valid_d = 1'b1;
                  if_rdata_d     = mem_rdata;
               end
            end
         end

         default: begin
            state_d         = ST_IDLE;
            mem_req_valid_d = 1'b0;
            busy_d          = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         owner_q         <= OWN_IF;
         starve_q        <= '0;
         addr_q          <= '0;
         we_q            <= 1'b0;
         wdata_q         <= '0;
         wstrb_q         <= '0;
         mem_req_valid_q <= 1'b0;
         busy_q          <= 1'b0;
         if_rsp_valid_q  <= 1'b0;
         if_rdata_q      <= '0;
         d_rsp_valid_q   <= 1'b0;
         d_rdata_q       <= '0;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         starve_q        <= starve_d;
         addr_q          <= addr_d;
         we_q            <= we_d;
         wdata_q         <= wdata_d;
         wstrb_q         <= wstrb_d;
         mem_req_valid_q <= mem_req_valid_d;
         busy_q          <= busy_d;
         if_rsp_valid_q  <= if_rsp_valid_d;
         if_rdata_q      <= if_rdata_d;
         d_rsp_valid_q   <= d_rsp_valid_d;
         d_rdata_q       <= d_rdata_d;
      end
   end

   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = addr_q;
   assign mem_we        = we_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign if_rsp_valid  = if_rsp_valid_q;
   assign if_rdata      = if_rdata_q;
   assign d_rsp_valid   = d_rsp_valid_q;
   assign d_rdata       = d_rdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios (fetch, store, load, request stall, late response with a
// stray response, continuous contention, reset mid-transaction) followed by a
// randomized run checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req_valid, d_req_ready, d_we, d_rsp_valid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req_valid  = 1'b0; if_addr = '0;
      d_req_valid   = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".if_req_ready"},  32'(if_req_ready),  0);
      check({tag, ".if_rsp_valid"},  32'(if_rsp_valid),  0);
      check({tag, ".if_rdata"},      if_rdata,           0);
      check({tag, ".d_req_ready"},   32'(d_req_ready),   0);
      check({tag, ".d_rsp_valid"},   32'(d_rsp_valid),   0);
      check({tag, ".d_rdata"},       d_rdata,            0);
      check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 0);
      check({tag, ".mem_addr"},      mem_addr,           0);
      check({tag, ".mem_we"},        32'(mem_we),        0);
      check({tag, ".mem_wdata"},     mem_wdata,          0);
      check({tag, ".mem_wstrb"},     32'(mem_wstrb),     0);
      check({tag, ".busy"},          32'(busy),          0);
   endtask

   // One transaction from an idle DUT. rdy_wait = cycles mem_req_ready stays
   // low (both requesters hammer valid meanwhile); rsp_wait = extra cycles
   // in RSP before mem_rsp_valid; spurious = stray response while idle first.
   task automatic single(input string tag, input bit dat, input logic [31:0] addr,
                         input logic we, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] rdata, input int rdy_wait, input int rsp_wait,
                         input bit spurious);
      logic        e_we;
      logic [31:0] e_wdata;
      logic [3:0]  e_strb;
      e_we    = dat & we;
      e_wdata = dat ? wdata : 32'h0;
      e_strb  = (dat && we) ? wstrb : 4'h0;
      if (spurious) begin
         mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
         step();
         mem_rsp_valid = 1'b0;
         check({tag, ".spur_if_rsp"}, 32'(if_rsp_valid), 0);
         check({tag, ".spur_d_rsp"},  32'(d_rsp_valid),  0);
         check({tag, ".spur_busy"},   32'(busy),         0);
      end
      if (dat) begin
         d_req_valid = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata; d_wstrb = wstrb;
      end else begin
         if_req_valid = 1'b1; if_addr = addr;
      end
      #1;
      check({tag, ".if_ready"}, 32'(if_req_ready), 32'(!dat));
      check({tag, ".d_ready"},  32'(d_req_ready),  32'(dat));
      step();
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      for (int i = 0; i <= rdy_wait; i++) begin
         check({tag, ".req_valid"}, 32'(mem_req_valid), 1);
         check({tag, ".addr"},      mem_addr,           addr);
         check({tag, ".we"},        32'(mem_we),        32'(e_we));
         check({tag, ".wdata"},     mem_wdata,          e_wdata);
         check({tag, ".wstrb"},     32'(mem_wstrb),     32'(e_strb));
         check({tag, ".busy"},      32'(busy),          1);
         if (i < rdy_wait) begin
            mem_req_ready = 1'b0; if_req_valid = 1'b1; d_req_valid = 1'b1;
            #1;
            check({tag, ".stall_if_ready"}, 32'(if_req_ready), 0);
            check({tag, ".stall_d_ready"},  32'(d_req_ready),  0);
         end else begin
            mem_req_ready = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
         end
         step();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_wait; i++) begin
         check({tag, ".wait_req_valid"}, 32'(mem_req_valid), 0);
         check({tag, ".wait_busy"},      32'(busy),          1);
         check({tag, ".wait_rsp"},       32'(if_rsp_valid | d_rsp_valid), 0);
         step();
      end
      mem_rsp_valid = 1'b1; mem_rdata = rdata;
      step();
      mem_rsp_valid = 1'b0; mem_rdata = 32'h0BAD_F00D;
      check({tag, ".if_rsp"}, 32'(if_rsp_valid), 32'(!dat));
      check({tag, ".d_rsp"},  32'(d_rsp_valid),  32'(dat));
      if (dat) check({tag, ".d_rdata"}, d_rdata, we ? 32'h0 : rdata);
      else     check({tag, ".if_rdata"}, if_rdata, rdata);
      check({tag, ".busy_end"}, 32'(busy), 0);
      step();
      check({tag, ".pulse_end"}, 32'(if_rsp_valid | d_rsp_valid), 0);
   endtask

   // Transaction-level reference model state for the random run.
   typedef struct {
      bit          dat;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   initial begin
      txn_t        cur, done, ifq, dq;
      bit          if_pend, d_pend, m_active, m_hs, rsp_due, pend, last_dat;
      int          streak, dly, win, grants, nrsp;
      logic [31:0] exp_if_rdata, exp_d_rdata, pend_data, last_addr;
      logic [9:0]  seq;

      idle_inputs();
      #1;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();

      single("fetch", 1'b0, 32'h100,  1'b0, 32'h0,         4'h0, 32'h0050_0093, 0, 0, 1'b0);
      single("store", 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 0, 0, 1'b0);
      single("load",  1'b1, 32'h2004, 1'b0, 32'hCAFE_0000, 4'hF, 32'h89AB_CDEF, 1, 2, 1'b0);
      single("stall", 1'b0, 32'h180,  1'b0, 32'h0,         4'h0, 32'h1111_2222, 5, 0, 1'b0);
      single("late",  1'b1, 32'h2400, 1'b0, 32'h0,         4'h0, 32'h5555_AAAA, 0, 7, 1'b1);

      // Continuous contention; memory echoes the address as read data.
      if_req_valid = 1'b1; d_req_valid = 1'b1; d_we = 1'b0; mem_req_ready = 1'b1;
      grants = 0; nrsp = 0; seq = '0; pend = 1'b0; pend_data = '0;
      last_dat = 1'b0; last_addr = '0;
      for (int c = 0; c < 80 && !(grants >= 10 && nrsp >= 10); c++) begin
         if (grants >= 10) begin if_req_valid = 1'b0; d_req_valid = 1'b0; end
         if_addr = 32'h4000 + 32'(grants * 4);
         d_addr  = 32'h3000 + 32'(grants * 4);
         mem_rsp_valid = pend; mem_rdata = pend_data;
         pend = mem_req_valid; pend_data = mem_addr;
         #1;
         if (if_req_ready || d_req_ready) begin
            seq       = {seq[8:0], d_req_ready};
            last_dat  = d_req_ready;
            last_addr = d_req_ready ? d_addr : if_addr;
            grants++;
         end
         step();
         if (if_rsp_valid || d_rsp_valid) begin
            check("arb.route", 32'(d_rsp_valid), 32'(last_dat));
            check("arb.rdata", last_dat ? d_rdata : if_rdata, last_addr);
            nrsp++;
         end
      end
      check("arb.order",     32'(seq), 32'(10'b1111011110));
      check("arb.rsp_count", nrsp,     10);
      idle_inputs();
      step();

      // Reset while waiting for the memory response.
      if_req_valid = 1'b1; if_addr = 32'h500;
      step();
      if_req_valid = 1'b0; mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      check("rst.busy_before", 32'(busy), 1);
      #2;
      reset_n = 1'b0; if_req_valid = 1'b1; d_req_valid = 1'b1; mem_rsp_valid = 1'b1;
      #1;
      check_outputs_zero("rst_async");
      step();
      check_outputs_zero("rst_held");
      idle_inputs();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst.no_rsp",  32'(if_rsp_valid | d_rsp_valid), 0);
         check("rst.no_busy", 32'(busy), 0);
      end

      // Randomized run against the reference model.
      if_pend = 1'b0; d_pend = 1'b0; m_active = 1'b0; m_hs = 1'b0; rsp_due = 1'b0;
      streak = 0; dly = 0; exp_if_rdata = '0; exp_d_rdata = '0;
      cur  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0};
      done = cur; ifq = cur; dq = cur;
      for (int c = 0; c < 4000; c++) begin
         check("rnd.busy",          32'(busy),          32'(m_active));
         check("rnd.mem_req_valid", 32'(mem_req_valid), 32'(m_active && !m_hs));
         if (m_active && !m_hs) begin
            check("rnd.mem_addr",  mem_addr,        cur.addr);
            check("rnd.mem_we",    32'(mem_we),     32'(cur.we));
            check("rnd.mem_wdata", mem_wdata,       cur.dat ? cur.wdata : 32'h0);
            check("rnd.mem_wstrb", 32'(mem_wstrb),  cur.we ? 32'(cur.wstrb) : 32'h0);
         end
         check("rnd.if_rsp_valid", 32'(if_rsp_valid), 32'(rsp_due && !done.dat));
         check("rnd.d_rsp_valid",  32'(d_rsp_valid),  32'(rsp_due && done.dat));
         check("rnd.if_rdata", if_rdata, exp_if_rdata);
         check("rnd.d_rdata",  d_rdata,  exp_d_rdata);

         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1;
            ifq = '{1'b0, $urandom, 1'b0, 32'h0, 4'h0};
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1'b1;
            dq = '{1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15))};
         end
         if_req_valid = if_pend; if_addr = ifq.addr;
         d_req_valid = d_pend; d_addr = dq.addr; d_we = dq.we; d_wdata = dq.wdata; d_wstrb = dq.wstrb;
         mem_req_ready = ($urandom_range(0, 2) != 0);
         if (m_hs) mem_rsp_valid = (dly == 0);
         else      mem_rsp_valid = ($urandom_range(0, 5) == 0);
         mem_rdata = $urandom;

         win = 0;
         if (!m_active) begin
            if (if_pend && d_pend) win = (streak == LIMIT) ? 1 : 2;
            else if (d_pend)       win = 2;
            else if (if_pend)      win = 1;
         end
         #1;
         check("rnd.if_req_ready", 32'(if_req_ready), 32'(win == 1));
         check("rnd.d_req_ready",  32'(d_req_ready),  32'(win == 2));

         @(posedge clk);
         rsp_due = 1'b0;
         if (m_active && m_hs && mem_rsp_valid) begin
            done = cur; rsp_due = 1'b1; m_active = 1'b0; m_hs = 1'b0;
            if (cur.dat) exp_d_rdata  = cur.we ? 32'h0 : mem_rdata;
            else         exp_if_rdata = mem_rdata;
         end else if (m_active && m_hs) begin
            dly--;
         end else if (m_active && mem_req_ready) begin
            m_hs = 1'b1; dly = $urandom_range(0, 4);
         end
         if (win == 1) begin
            cur = ifq; if_pend = 1'b0; streak = 0; m_active = 1'b1;
         end else if (win == 2) begin
            cur = dq; d_pend = 1'b0; m_active = 1'b1;
            if (if_pend) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
         end
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
